// File: rtl/data_sweep_master.sv
// Read-only bus initiator: sweeps a word range from data memory and folds it
// into a rotate-XOR signature, with at most two requests outstanding.
module data_sweep_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [COUNT_WIDTH-1:0] word_count_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  checksum_o,
  output logic                   err_o,
  output logic                   data_req_o,
  input  logic                   data_gnt_i,
  input  logic                   data_rvalid_i,
  output logic                   data_we_o,
  output logic [3:0]             data_be_o,
  output logic [ADDR_WIDTH-1:0]  data_addr_o,
  output logic [DATA_WIDTH-1:0]  data_wdata_o,
  input  logic [DATA_WIDTH-1:0]  data_rdata_i,
  input  logic                   data_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [ADDR_WIDTH-1:0]  base;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] issued;
  logic [COUNT_WIDTH-1:0] received;
  logic [1:0]             outstanding;
  logic [DATA_WIDTH-1:0]  checksum;
  logic                   err;

  logic                   running;
  logic                   fire;
  logic                   resp;
  logic                   last_resp;
  logic [COUNT_WIDTH:0]   received_inc;
  logic [ADDR_WIDTH-1:0]  offset;

  assign running      = (state == RUN);
  assign data_req_o   = running && (issued < count) && (outstanding < 2'd2);
  assign fire         = data_req_o && data_gnt_i;
  assign resp         = running && data_rvalid_i;
  assign received_inc = {1'b0, received} + {{COUNT_WIDTH{1'b0}}, 1'b1};
  // Finishing on the final response itself keeps done one cycle after the last rvalid.
  assign last_resp    = resp && (received_inc == {1'b0, count});
  assign offset       = ADDR_WIDTH'({issued, 2'b00});

  assign data_addr_o  = base + offset;
  assign data_we_o    = 1'b0;
  assign data_be_o    = 4'b1111;
  assign data_wdata_o = '0;
  assign busy_o       = running;
  assign done_o       = (state == DONE);
  assign checksum_o   = checksum;
  assign err_o        = err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      base        <= '0;
      count       <= '0;
      issued      <= '0;
      received    <= '0;
      outstanding <= '0;
      checksum    <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            base        <= base_addr_i & ~ADDR_WIDTH'(3);
            count       <= word_count_i;
            issued      <= '0;
            received    <= '0;
            outstanding <= '0;
            checksum    <= '0;
            err         <= 1'b0;
            state       <= (word_count_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (fire) begin
            issued <= issued + COUNT_WIDTH'(1);
          end
          case ({fire, resp})
            2'b10:   outstanding <= outstanding + 2'd1;
            2'b01:   outstanding <= outstanding - 2'd1;
            default: outstanding <= outstanding;
          endcase
          if (resp) begin
            received <= received_inc[COUNT_WIDTH-1:0];
            // Errored words are skipped so the signature only covers good data.
            if (data_err_i) begin
              err <= 1'b1;
            end else begin
              checksum <= {checksum[DATA_WIDTH-2:0], checksum[DATA_WIDTH-1]} ^ data_rdata_i;
            end
            if (last_resp) begin
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
